alu_issue_stage: RTL and testbench

//  Issue/retire stage wrapped around the combinational N-bit ALU.
//  - Buffers {sel,a,b} commands from the decode side in a small FIFO and drives the ALU from the FIFO head.
//  - Registers the ALU result and flags into a valid/ready output slot.
//  - Decouples the ALU from back-pressure on both sides.

---
 rtl/alu_issue_stage_pkg.sv | 23 ++
 rtl/alu_issue_stage_cmd_fifo.sv | 53 +++++
 rtl/alu_issue_stage.sv | 118 +++++++++++
 tb/tb_alu_issue_stage.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU issue stage: opcode encoding and the
// command word layout {sel, a, b} used by the decode side, FIFO and ALU.
package alu_issue_stage_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_NOT = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_CMP = 3'd6,
    OP_EQU = 3'd7
  } alu_op_e;

  // Width of one packed command {sel, a, b} for an n-bit datapath.
  function automatic int unsigned cmd_width(input int unsigned n);
    return OP_W + 2 * n;
  endfunction

endpackage

// File: rtl/alu_issue_stage_cmd_fifo.sv
// alu_cmd_fifo: synchronous FIFO holding packed ALU commands.
// Push is refused while full and pop while empty; count reports occupancy.
module alu_cmd_fifo #(
  parameter int unsigned W     = 11,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               wr_data,
  input  logic                       pop,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop  && (count != '0);
  assign rd_data = mem[rd_ptr];

  // Storage array: written on accepted push, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^k)
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: buffers decoded ALU commands, drives the external ALU
// from the FIFO head and registers the result into a valid/ready slot.
// Optional feature macro: STICKY_FLAGS_EN (sticky carry/overflow with clear).
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [OP_W-1:0]            in_sel,
  input  logic [N-1:0]               in_a,
  input  logic [N-1:0]               in_b,
  output logic [OP_W-1:0]            alu_sel,
  output logic [N-1:0]               alu_a,
  output logic [N-1:0]               alu_b,
  input  logic [N-1:0]               alu_s,
  input  logic                       alu_carry,
  input  logic                       alu_zero,
  input  logic                       alu_overflow,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OP_W-1:0]            out_sel,
  output logic [N-1:0]               out_s,
  output logic                       out_carry,
  output logic                       out_zero,
  output logic                       out_overflow,
  output logic [$clog2(DEPTH):0]     level
`ifdef STICKY_FLAGS_EN
  ,
  input  logic                       flag_clr,
  output logic                       sticky_carry,
  output logic                       sticky_overflow
`endif
);

  localparam int unsigned CMD_W = cmd_width(N);
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic [CMD_W-1:0] wr_cmd;
  logic [CMD_W-1:0] head;
  logic [LW-1:0]    count;
  logic             push;
  logic             nonempty;
  logic             capture;
  alu_op_e          head_sel;

  assign wr_cmd   = {in_sel, in_a, in_b};
  assign in_ready = (count != LW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign nonempty = (count != '0);
  assign capture  = nonempty && (!out_valid || out_ready);
  assign level    = count;
  assign head_sel = alu_op_e'(head[CMD_W-1 -: OP_W]);

  alu_cmd_fifo #(
    .W     (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (wr_cmd),
    .pop     (capture),
    .rd_data (head),
    .count   (count)
  );

  // Present the FIFO head to the ALU, forcing zeros while the FIFO is empty
  always_comb begin
    alu_sel = '0;
    alu_a   = '0;
    alu_b   = '0;
    if (nonempty) begin
      alu_sel = head_sel;
      alu_a   = head[2*N-1 -: N];
      alu_b   = head[N-1:0];
    end
  end

  // Output slot: capture the ALU result for the head command, or release on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_sel      <= '0;
      out_s        <= '0;
      out_carry    <= 1'b0;
      out_zero     <= 1'b0;
      out_overflow <= 1'b0;
    end else if (capture) begin
      out_valid    <= 1'b1;
      out_sel      <= head_sel;
      out_s        <= alu_s;
      out_carry    <= alu_carry;
      out_zero     <= alu_zero;
      out_overflow <= alu_overflow;
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end

`ifdef STICKY_FLAGS_EN
  // Sticky flags: a clear coincident with a capture still keeps the new flag
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_carry    <= 1'b0;
      sticky_overflow <= 1'b0;
    end else begin
      sticky_carry    <= (flag_clr ? 1'b0 : sticky_carry)    | (capture & alu_carry);
      sticky_overflow <= (flag_clr ? 1'b0 : sticky_overflow) | (capture & alu_overflow);
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage with a behavioural ALU attached.
// Optional feature macro: STICKY_FLAGS_EN (enables the sticky flag tests).
module tb_alu_issue_stage;

  localparam int unsigned N     = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = 3;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_sel;
  logic [N-1:0]  in_a;
  logic [N-1:0]  in_b;
  logic [2:0]    alu_sel;
  logic [N-1:0]  alu_a;
  logic [N-1:0]  alu_b;
  logic [N-1:0]  alu_s;
  logic          alu_carry;
  logic          alu_zero;
  logic          alu_overflow;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    out_sel;
  logic [N-1:0]  out_s;
  logic          out_carry;
  logic          out_zero;
  logic          out_overflow;
  logic [LW-1:0] level;
`ifdef STICKY_FLAGS_EN
  logic          flag_clr;
  logic          sticky_carry;
  logic          sticky_overflow;
`endif

  typedef struct {
    logic [2:0]   sel;
    logic [N-1:0] s;
    logic         c;
    logic         z;
    logic         v;
  } res_t;

  res_t exp_q[$];
  res_t alu_r;
  int   checks;
  int   passed;

  alu_issue_stage #(
    .N     (N),
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sel       (in_sel),
    .in_a         (in_a),
    .in_b         (in_b),
    .alu_sel      (alu_sel),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_s        (alu_s),
    .alu_carry    (alu_carry),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sel      (out_sel),
    .out_s        (out_s),
    .out_carry    (out_carry),
    .out_zero     (out_zero),
    .out_overflow (out_overflow),
    .level        (level)
`ifdef STICKY_FLAGS_EN
    ,
    .flag_clr        (flag_clr),
    .sticky_carry    (sticky_carry),
    .sticky_overflow (sticky_overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU semantics in plain integer arithmetic
  function automatic res_t ref_alu(input logic [2:0] sel, input logic [N-1:0] a, input logic [N-1:0] b);
    res_t r;
    int ua, ub, sa, sb, t;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= (1 << (N - 1))) ? ua - (1 << N) : ua;
    sb = (ub >= (1 << (N - 1))) ? ub - (1 << N) : ub;
    r.sel = sel;
    r.c   = 1'b0;
    r.v   = 1'b0;
    case (sel)
      3'd0: begin
        t = ua + ub;
        r.s = N'(t);
        r.c = (t >= (1 << N));
        r.v = ((sa + sb) > 7) || ((sa + sb) < -8);
      end
      3'd1: begin
        t = ua - ub;
        r.s = N'(t);
        r.c = (ua < ub);
        r.v = ((sa - sb) > 7) || ((sa - sb) < -8);
      end
      3'd2:    r.s = ~a;
      3'd3:    r.s = a & b;
      3'd4:    r.s = a | b;
      3'd5:    r.s = a ^ b;
      3'd6:    r.s = (ua < ub) ? {N{1'b1}} : '0;
      default: r.s = (ua == ub) ? {N{1'b1}} : '0;
    endcase
    r.z = (r.s == '0);
    return r;
  endfunction

  // The attached "real" ALU, combinational from the issue stage outputs
  always_comb begin
    alu_r        = ref_alu(alu_sel, alu_a, alu_b);
    alu_s        = alu_r.s;
    alu_carry    = alu_r.c;
    alu_zero     = alu_r.z;
    alu_overflow = alu_r.v;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: compares the output slot with the oldest outstanding command
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(out_s), 32'hFFFF_FFFF);
        end else begin
          chk("result", {out_sel, out_s, out_carry, out_zero, out_overflow},
              {exp_q[0].sel, exp_q[0].s, exp_q[0].c, exp_q[0].z, exp_q[0].v});
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (level == '0) chk("alu_idle_zero", {alu_sel, alu_a, alu_b}, 32'h0);
      if (in_valid && in_ready) exp_q.push_back(ref_alu(in_sel, in_a, in_b));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] sel, input logic [N-1:0] a, input logic [N-1:0] b);
    in_valid = 1'b1;
    in_sel   = sel;
    in_a     = a;
    in_b     = b;
  endtask

  task automatic drive_rand();
    drive(3'($urandom_range(0, 7)), N'($urandom_range(0, 15)), N'($urandom_range(0, 15)));
  endtask

  // Single command with a free output: result is in the slot two edges later
  task automatic send_one(input logic [2:0] sel, input logic [N-1:0] a, input logic [N-1:0] b);
    drive(sel, a, b);
    step();
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    checks    = 0;
    passed    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sel    = '0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
`ifdef STICKY_FLAGS_EN
    flag_clr  = 1'b0;
`endif
    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_fields", {out_sel, out_s, out_carry, out_zero, out_overflow}, 32'h0);
    rst = 1'b0;
    step();

    // Basic latency and results
    out_ready = 1'b1;
    drive(3'd0, 4'd3, 4'd4);
    step();
    in_valid = 1'b0;
    chk("lat_not_yet_valid", 32'(out_valid), 32'd0);
    chk("lat_level_one", 32'(level), 32'd1);
    step();
    chk("add34_valid", 32'(out_valid), 32'd1);
    chk("add34", {out_s, out_carry, out_zero, out_overflow}, {4'd7, 3'b000});
    step();
    send_one(3'd1, 4'd5, 4'd5);
    chk("sub55", {out_s, out_zero}, {4'd0, 1'b1});
    send_one(3'd0, 4'd7, 4'd1);
    chk("add71", {out_s, out_overflow}, {4'd8, 1'b1});
    send_one(3'd6, 4'd2, 4'd5);
    chk("cmp25", 32'(out_s), 32'hF);
    step();

    // Back-pressure: six offered, five accepted
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_rand();
      step();
    end
    in_valid = 1'b0;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_level", 32'(level), 32'd4);
    chk("full_outstanding", 32'(exp_q.size()), 32'd5);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("burst_valid", 32'(out_valid), 32'd1);
      step();
    end
    chk("burst_done_valid", 32'(out_valid), 32'd0);
    chk("burst_done_level", 32'(level), 32'd0);

    // Steady state at level 2 with push+pop every cycle
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_rand();
      step();
    end
    chk("steady_level_init", 32'(level), 32'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive_rand();
      step();
      chk("steady_level", 32'(level), 32'd2);
    end
    in_valid = 1'b0;
    repeat (4) step();
    chk("steady_drain_level", 32'(level), 32'd0);
    chk("steady_drain_valid", 32'(out_valid), 32'd0);

    // Reset while full with a pending result
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_rand();
      step();
    end
    in_valid = 1'b0;
    chk("prerst_level", 32'(level), 32'd4);
    chk("prerst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (5) step();
    chk("postrst_no_stale", 32'(out_valid), 32'd0);

`ifdef STICKY_FLAGS_EN
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    chk("sticky_clr_init", {sticky_carry, sticky_overflow}, 32'd0);
    send_one(3'd0, 4'd7, 4'd1);
    chk("sticky_ovf_set", 32'(sticky_overflow), 32'd1);
    send_one(3'd0, 4'd1, 4'd1);
    chk("sticky_ovf_hold", 32'(sticky_overflow), 32'd1);
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    chk("sticky_ovf_clr", 32'(sticky_overflow), 32'd0);
    drive(3'd0, 4'd7, 4'd1);
    step();
    in_valid = 1'b0;
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    chk("sticky_clr_with_capture", {sticky_carry, sticky_overflow}, 32'b01);
    step();
`endif

    // Randomised traffic with random back-pressure
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 7) drive_rand();
      else in_valid = 1'b0;
      out_ready = ($urandom_range(0, 9) < 6);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    begin
      int budget;
      budget = 50;
      while ((out_valid || level != '0) && budget > 0) begin
        step();
        budget--;
      end
      chk("drain_in_budget", 32'(out_valid || level != '0), 32'd0);
    end
    step();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
